core_mul_unit: RTL and testbench

CORE_MUL_UNIT -- requirements
Module: core_mul_unit

---
 rtl/core_mul_unit.sv | 162 ++++++++++++++++
 tb/tb_core_mul_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/core_mul_unit.sv
// Multi-cycle 32x32 multiply-accumulate unit: 8 multiplier bits per cycle, then accumulate.
// Optional MUL_EARLY_TERM_EN leaves CALC as soon as the remaining multiplier bits are zero.
module core_mul_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mul_en,
   input  logic        instruction_valid,
   input  logic [1:0]  mul_mode,
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   input  logic [31:0] ops_l,
   input  logic [31:0] ops_h,
   input  logic        flush,
   input  logic        out_ready,
   output logic        in_ready,
   output logic        busy,
   output logic        out_valid,
   output logic [31:0] result_l,
   output logic [31:0] result_h,
   output logic        flag_n,
   output logic        flag_z
);

   localparam int unsigned DW          = 32;
   localparam int unsigned PW          = 64;
   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned CALC_CYCLES = 4;
   localparam int unsigned CW          = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      ACC  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state;
   state_t          state_next;
   logic            accept;
   logic            calc_last;

   logic [PW-1:0]   mcand;
   logic [DW-1:0]   mplier;
   logic [PW-1:0]   prod;
   logic [CW-1:0]   cnt;
   logic            neg;
   logic            long_mode;

   logic            signed_in;
   logic [DW-1:0]   abs_op1;
   logic [DW-1:0]   abs_op2;
   logic [PW-1:0]   step_sum;
   logic [PW-1:0]   signed_prod;
   logic [PW-1:0]   addend;
   logic [PW-1:0]   acc_sum;
   logic [PW-1:0]   acc_res;
   logic            res_n;
   logic            res_z;

`ifdef MUL_EARLY_TERM_EN
   assign calc_last = (cnt == CW'(CALC_CYCLES - 1)) || (mplier[DW-1:BYTE_W] == '0);
`else
   assign calc_last = (cnt == CW'(CALC_CYCLES - 1));
`endif

   // Next-state logic
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (mul_en && instruction_valid && in_ready && !flush) begin
               accept     = 1'b1;
               state_next = CALC;
            end
         end
         CALC: begin
            if (flush)          state_next = IDLE;
            else if (calc_last) state_next = ACC;
         end
         ACC: begin
            state_next = flush ? IDLE : DONE;
         end
         DONE: begin
            if (flush || out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Operand magnitudes, one shift-add step and the final accumulate
   always_comb begin
      signed_in = mul_mode[1] & mul_mode[0];
      abs_op1   = (signed_in && op1[DW-1]) ? DW'(~op1 + DW'(1)) : op1;
      abs_op2   = (signed_in && op2[DW-1]) ? DW'(~op2 + DW'(1)) : op2;

      step_sum = prod;
      for (int i = 0; i < int'(BYTE_W); i++) begin
         if (mplier[i]) step_sum = step_sum + (mcand << i);
      end

      signed_prod = neg ? PW'(~prod + PW'(1)) : prod;
      addend      = long_mode ? {ops_h, ops_l} : {32'h0, ops_l};
      acc_sum     = signed_prod + addend;
      acc_res     = long_mode ? acc_sum : {32'h0, acc_sum[DW-1:0]};
      res_n       = long_mode ? acc_res[PW-1] : acc_res[DW-1];
      res_z       = long_mode ? (acc_res == '0) : (acc_res[DW-1:0] == '0);
   end

   // State register and registered handshake outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state     <= state_next;
         busy      <= (state_next != IDLE);
         in_ready  <= (state_next == IDLE);
         out_valid <= (state_next == DONE);
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand     <= '0;
         mplier    <= '0;
         prod      <= '0;
         cnt       <= '0;
         neg       <= 1'b0;
         long_mode <= 1'b0;
         result_l  <= '0;
         result_h  <= '0;
         flag_n    <= 1'b0;
         flag_z    <= 1'b0;
      end else begin
         if (accept) begin
            mcand     <= PW'(abs_op1);
            mplier    <= abs_op2;
            prod      <= '0;
            cnt       <= '0;
            neg       <= signed_in & (op1[DW-1] ^ op2[DW-1]);
            long_mode <= mul_mode[1];
         end else if (state == CALC) begin
            prod   <= step_sum;
            mcand  <= mcand << BYTE_W;
            mplier <= mplier >> BYTE_W;
            cnt    <= cnt + CW'(1);
         end
         // Results only change on the ACC edge, so they hold steady through DONE
         if (state == ACC && !flush) begin
            result_l <= acc_res[DW-1:0];
            result_h <= acc_res[PW-1:DW];
            flag_n   <= res_n;
            flag_z   <= res_z;
         end
      end
   end

endmodule

// File: tb/tb_core_mul_unit.sv
// Randomized self-checking bench for core_mul_unit against an arithmetic reference model.
module tb_core_mul_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mul_en = 1'b0;
   logic        instruction_valid = 1'b0;
   logic [1:0]  mul_mode = 2'b00;
   logic [31:0] op1 = '0;
   logic [31:0] op2 = '0;
   logic [31:0] ops_l = '0;
   logic [31:0] ops_h = '0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ready;
   logic        busy;
   logic        out_valid;
   logic [31:0] result_l;
   logic [31:0] result_h;
   logic        flag_n;
   logic        flag_z;

   int n_checks = 0;
   int n_pass   = 0;

   core_mul_unit dut (
      .clk(clk), .rst_n(rst_n), .mul_en(mul_en), .instruction_valid(instruction_valid),
      .mul_mode(mul_mode), .op1(op1), .op2(op2), .ops_l(ops_l), .ops_h(ops_h),
      .flush(flush), .out_ready(out_ready), .in_ready(in_ready), .busy(busy),
      .out_valid(out_valid), .result_l(result_l), .result_h(result_h),
      .flag_n(flag_n), .flag_z(flag_z)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] model(input logic [1:0] mode, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] l,
                                         input logic [31:0] h);
      longint      sp;
      logic [31:0] s;
      if (mode == 2'b11) begin
         sp = longint'($signed(a)) * longint'($signed(b));
         return 64'(sp) + {h, l};
      end else if (mode[1]) begin
         return ({32'h0, a} * {32'h0, b}) + {h, l};
      end
      s = a * b + l;
      return {32'h0, s};
   endfunction

   function automatic int lat_model(input logic [1:0] mode, input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
      logic [31:0] mag;
      int          calc;
      mag  = (mode == 2'b11 && b[31]) ? (32'h0 - b) : b;
      calc = 1;
      for (int i = 1; i < 4; i++)
         if (mag[8*i +: 8] != 8'h0) calc = i + 1;
      return calc + 1;
`else
      return (mode == 2'b11) ? 5 : 5;
`endif
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_busy"},     64'(busy),     64'd0);
      check({tag, "_valid"},    64'(out_valid), 64'd0);
   endtask

   task automatic do_mul(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] l, input logic [31:0] h, input int hold,
                         input bit poke);
      logic [63:0] exp;
      logic [31:0] exp_h;
      logic        exp_n;
      logic        exp_z;
      int          n;
      exp   = model(mode, a, b, l, h);
      exp_h = mode[1] ? exp[63:32] : 32'h0;
      exp_n = mode[1] ? exp[63] : exp[31];
      exp_z = mode[1] ? (exp == 64'h0) : (exp[31:0] == 32'h0);
      n = 0;
      while (!in_ready && n < 20) begin tick(); n++; end
      check("ready_before_accept", 64'(in_ready), 64'd1);
      mul_mode = mode; op1 = a; op2 = b; ops_l = l; ops_h = h;
      mul_en = 1'b1; instruction_valid = 1'b1;
      tick();
      check("busy_after_accept", 64'(busy), 64'd1);
      // A held request while busy must not disturb the latched operands
      if (poke) begin
         op1 = $urandom; op2 = $urandom; mul_mode = 2'($urandom);
      end else begin
         mul_en = 1'b0;
      end
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
         mul_en = 1'b0;
      end
      check("latency", 64'(n), 64'(lat_model(mode, b)));
      for (int c = 0; c <= hold; c++) begin
         check("result_l", 64'(result_l), 64'(exp[31:0]));
         check("result_h", 64'(result_h), 64'(exp_h));
         check("flag_n",   64'(flag_n),   64'(exp_n));
         check("flag_z",   64'(flag_z),   64'(exp_z));
         check("valid_held", 64'(out_valid), 64'd1);
         if (c < hold) tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_idle_outputs("after_done");
   endtask

   logic [31:0] specials [6];

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      bit          seen_valid;
      specials[0] = 32'h0000_0000; specials[1] = 32'hFFFF_FFFF;
      specials[2] = 32'h8000_0000; specials[3] = 32'h0000_0001;
      specials[4] = 32'h7FFF_FFFF; specials[5] = 32'h0001_0000;

      // Reset state
      tick(); tick();
      check_idle_outputs("reset");
      check("reset_result_l", 64'(result_l), 64'd0);
      check("reset_result_h", 64'(result_h), 64'd0);
      check("reset_flags", 64'({flag_n, flag_z}), 64'd0);
      rst_n = 1'b1;
      tick();

      // Directed scenarios
      do_mul(2'b00, 32'd7, 32'd6, 32'd0, 32'd0, 0, 1'b0);
      do_mul(2'b11, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 1, 1'b0);
      do_mul(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1'b0);
      do_mul(2'b00, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 0, 1'b0);
      do_mul(2'b00, 32'd1234, 32'd0, 32'd0, 32'd0, 0, 1'b0);
      do_mul(2'b11, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 0, 1'b1);
      do_mul(2'b11, 32'h8000_0000, 32'd1, 32'd5, 32'd0, 0, 1'b0);
      do_mul(2'b01, 32'hFFFF_FFFF, 32'd3, 32'd2, 32'h55, 3, 1'b0);
      do_mul(2'b00, 32'd100, 32'd200, 32'd7, 32'd0, 3, 1'b1);

      // Qualifier and flush gating in IDLE
      mul_en = 1'b1; instruction_valid = 1'b0;
      tick();
      check("iv_low_ignored", 64'(busy), 64'd0);
      instruction_valid = 1'b1; flush = 1'b1;
      tick();
      check("flush_idle_blocks", 64'(busy), 64'd0);
      mul_en = 1'b0; instruction_valid = 1'b0; flush = 1'b0;

      // Flush in the second CALC cycle
      mul_mode = 2'b10; op1 = 32'd9; op2 = 32'hFFFF_FFFF; ops_l = 0; ops_h = 0;
      mul_en = 1'b1; instruction_valid = 1'b1;
      tick();
      mul_en = 1'b0;
      tick();
      check("calc_busy", 64'(busy), 64'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_idle_outputs("flush_calc");
      seen_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (out_valid) seen_valid = 1'b1;
      end
      check("flush_no_valid", 64'(seen_valid), 64'd0);

      // Reset while in ACC
      mul_mode = 2'b11; op1 = 32'h1234_5678; op2 = 32'hFFFF_FFFF;
      mul_en = 1'b1; instruction_valid = 1'b1;
      tick();
      mul_en = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("acc_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      tick();
      check_idle_outputs("reset_acc");
      check("reset_acc_result", 64'({result_h, result_l}), 64'd0);
      check("reset_acc_flags", 64'({flag_n, flag_z}), 64'd0);
      rst_n = 1'b1;
      tick();
      do_mul(2'b11, 32'hFFFF_FFF9, 32'd6, 32'd0, 32'd0, 0, 1'b0);

      // Randomized transactions
      for (int t = 0; t < 40; t++) begin
         a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : ($urandom >> $urandom_range(0, 31));
         do_mul(2'($urandom), a, b,
                ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom,
                ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom,
                int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
